// File: rtl/shifter_pkg.sv
// Shared types and the per-stage shift function for the pipelined barrel shifter.
// Stages zero-extend their word to MAX_W bits before calling stage_shift.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } shifter_op_t;

    localparam int MAX_W = 64;

    // The word must be zero above bit width-1. SRA fills from the sign captured at input.
    function automatic logic [MAX_W-1:0] stage_shift(
        input logic [MAX_W-1:0] word,
        input shifter_op_t      op,
        input logic             sign,
        input int               width,
        input int               step
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] fill;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        fill = sign ? (mask & ~(mask >> step)) : '0;
        case (op)
            OP_ROR:  stage_shift = ((word >> step) | (word << (width - step))) & mask;
            OP_ROL:  stage_shift = ((word << step) | (word >> (width - step))) & mask;
            OP_SRL:  stage_shift = word >> step;
            default: stage_shift = (word >> step) | fill;
        endcase
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One registered log-shifter stage: moves the word by STEP when its amount bit is set.
// Word, amount, op and sign all move forward together so later stages can act on them.
module shifter_stage #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    input  logic                     in_sign,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_amt,
    output logic [1:0]               out_op,
    output logic                     out_sign
);
    import shifter_pkg::*;

    localparam int BIT = $clog2(STEP);

    logic [WIDTH-1:0] next_data;

    always_comb begin
        next_data = in_data;
        if (in_amt[BIT]) begin
            next_data = WIDTH'(stage_shift(MAX_W'(in_data), shifter_op_t'(in_op),
                                           in_sign, WIDTH, STEP));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_op    <= '0;
            out_sign  <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= next_data;
            out_amt   <= in_amt;
            out_op    <= in_op;
            out_sign  <= in_sign;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit: one registered stage per amount bit, valid/ready on both sides.
// The whole pipeline advances together; bubbles are carried rather than compressed.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);
    localparam int AMT_W = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two and >= 2");
    end

    logic             advance;
    logic [AMT_W:0]   valid_c;
    logic [AMT_W:0]   sign_c;
    logic [WIDTH-1:0] data_c [0:AMT_W];
    logic [AMT_W-1:0] amt_c  [0:AMT_W];
    logic [1:0]       op_c   [0:AMT_W];
    logic             unused_tail;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign valid_c[0] = in_valid && advance;
    assign data_c[0]  = in_data;
    assign amt_c[0]   = in_amt;
    assign op_c[0]    = in_op;
    assign sign_c[0]  = in_data[WIDTH-1];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .in_valid  (valid_c[k]),
            .in_data   (data_c[k]),
            .in_amt    (amt_c[k]),
            .in_op     (op_c[k]),
            .in_sign   (sign_c[k]),
            .out_valid (valid_c[k+1]),
            .out_data  (data_c[k+1]),
            .out_amt   (amt_c[k+1]),
            .out_op    (op_c[k+1]),
            .out_sign  (sign_c[k+1])
        );
    end

    assign out_valid = valid_c[AMT_W];
    assign out_data  = data_c[AMT_W];

    // The last stage's side-band fields have no consumer.
    assign unused_tail = ^{amt_c[AMT_W], op_c[AMT_W], sign_c[AMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors, streaming, stall, reset and width sweep.
module tb_pipelined_barrel_shifter;

    localparam logic [1:0] ROR = 2'b00, ROL = 2'b01, SRL = 2'b10, SRA = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;

    logic        w32_valid, w32_in_ready, w32_out_valid, w32_out_ready;
    logic [31:0] w32_data, w32_out_data;
    logic [4:0]  w32_amt;
    logic [1:0]  w32_op;

    logic       w2_valid, w2_in_ready, w2_out_valid, w2_out_ready;
    logic [1:0] w2_data, w2_out_data;
    logic [0:0] w2_amt;
    logic [1:0] w2_op;

    int         vectors     = 0;
    int         miscompares = 0;
    int         waits       = 0;
    logic [7:0] exp_q[$];

    pipelined_barrel_shifter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w32_valid), .in_ready(w32_in_ready),
        .in_data(w32_data), .in_amt(w32_amt), .in_op(w32_op),
        .out_valid(w32_out_valid), .out_ready(w32_out_ready), .out_data(w32_out_data)
    );

    pipelined_barrel_shifter #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(w2_valid), .in_ready(w2_in_ready),
        .in_data(w2_data), .in_amt(w2_amt), .in_op(w2_op),
        .out_valid(w2_out_valid), .out_ready(w2_out_ready), .out_data(w2_out_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bitwise reference, deliberately not staged like the RTL.
    function automatic logic [7:0] ref_model(input logic [7:0] d, input int a, input logic [1:0] op);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            case (op)
                ROR:     r[i] = d[(i + a) % 8];
                ROL:     r[i] = d[(i - a + 8) % 8];
                SRL:     r[i] = (i + a < 8) ? d[i + a] : 1'b0;
                default: r[i] = (i + a < 8) ? d[i + a] : d[7];
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] op,
                        input logic [7:0] exp);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
            waits++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_out_data", 64'(out_data), 64'(data_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0h, expected no output", out_data);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] op;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
        w32_valid = 1'b0; w32_data = '0; w32_amt = '0; w32_op = '0; w32_out_ready = 1'b1;
        w2_valid = 1'b0; w2_data = '0; w2_amt = '0; w2_op = '0; w2_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(8'h96, 3'd3, ROR, 8'hD2);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        check("w8_latency", 64'(lat), 64'd3);
        wait_drain("drain_first");

        send(8'h96, 3'd3, ROL, 8'hB4);
        send(8'h96, 3'd2, SRL, 8'h25);
        send(8'h96, 3'd2, SRA, 8'hE5);
        send(8'h96, 3'd7, SRA, 8'hFF);
        send(8'h96, 3'd0, ROR, 8'h96);
        send(8'h96, 3'd0, ROL, 8'h96);
        send(8'h96, 3'd0, SRL, 8'h96);
        send(8'h96, 3'd0, SRA, 8'h96);
        wait_drain("drain_directed");

        waits = 0;
        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom);
            a  = 3'($urandom_range(0, 7));
            op = 2'($urandom_range(0, 3));
            send(d, a, op, ref_model(d, int'(a), op));
        end
        check("stream_in_ready_waits", 64'(waits), 64'd0);
        wait_drain("drain_stream");

        out_ready = 1'b0;
        fork
            begin
                send(8'h12, 3'd1, ROR, 8'h09);
                send(8'h81, 3'd4, ROL, 8'h18);
                send(8'hF0, 3'd4, SRL, 8'h0F);
                send(8'h80, 3'd3, SRA, 8'hF0);
                send(8'h3C, 3'd1, ROL, 8'h78);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_pending", 64'(exp_q.size()), 64'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        send(8'h96, 3'd1, SRL, 8'h4B);
        send(8'h96, 3'd1, ROL, 8'h2D);
        send(8'h96, 3'd1, SRA, 8'hCB);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_stale", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(8'h96, 3'd3, ROL, 8'hB4);
        wait_drain("drain_post_reset");

        w32_valid = 1'b1; w32_data = 32'h8000_0001; w32_amt = 5'd31; w32_op = ROR;
        @(negedge clk);
        check("w32_in_ready", 64'(w32_in_ready), 64'd1);
        @(posedge clk);
        #1;
        w32_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!w32_out_valid && lat < 20);
        check("w32_latency", 64'(lat), 64'd5);
        check("w32_data", 64'(w32_out_data), 64'h0000_0003);

        w2_valid = 1'b1; w2_data = 2'b01; w2_amt = 1'b1; w2_op = ROL;
        @(posedge clk);
        #1;
        w2_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!w2_out_valid && lat < 20);
        check("w2_latency", 64'(lat), 64'd1);
        check("w2_data", 64'(w2_out_data), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
